// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB requester arbiter.
// State encoding plus parameter defaults used by all arbiter files.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  localparam int ARB_NUM_REQ_DEF = 4;
  localparam int ARB_ADDR_W_DEF  = 32;
  localparam int ARB_DATA_W_DEF  = 32;

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin search: first set request at or
// above ptr, ascending modulo NUM_REQ.
module apb_rr_picker
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ_DEF,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  // Scan offsets high to low so the smallest offset wins.
  always_comb begin
    int k;
    k       = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = int'(i_ptr) + i;
      if (k >= NUM_REQ) begin
        k = k - NUM_REQ;
      end
      if (i_req[k[IDX_W-1:0]]) begin
        o_found = 1'b1;
        o_idx   = k[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master among NUM_REQ
// requesters; one transfer outstanding at a time.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ_DEF,
  parameter int ADDR_W  = ARB_ADDR_W_DEF,
  parameter int DATA_W  = ARB_DATA_W_DEF,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                  i_clk_apb,
  input  logic                  i_rst_apb,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [NUM_REQ-1:0]    i_req_rd0_wr1,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wr_data,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic [NUM_REQ-1:0]    o_req_done,
  output logic [NUM_REQ-1:0]    o_req_rd_valid,
  output logic [DATA_W-1:0]     o_req_rd_data,
  output logic                  o_valid,
  output logic                  o_rd0_wr1,
  output logic [ADDR_W-1:0]     o_addr,
  output logic [DATA_W-1:0]     o_wr_data,
  input  logic                  i_ready,
  input  logic                  i_rd_valid,
  input  logic [DATA_W-1:0]     i_rd_data,
  output logic                  o_busy,
  output logic [IDX_W-1:0]      o_grant_id
);

  arb_state_t          r_state;
  arb_state_t          w_next;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_gid;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_flag;
  logic                w_found;
  logic [IDX_W-1:0]    w_idx;
  logic                w_grant;
  logic                w_done;

  apb_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  assign w_grant = (r_state == ARB_IDLE) && w_found;
  assign w_done  = (r_state == ARB_WAIT) && i_ready;

  always_ff @(posedge i_clk_apb) begin
    if (i_rst_apb) begin
      r_state   <= ARB_IDLE;
      r_ptr     <= '0;
      r_gid     <= '0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd_data <= '0;
      r_rd_flag <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_gid   <= w_idx;
        r_ptr   <= (w_idx == IDX_W'(NUM_REQ - 1)) ?
                   '0 : w_idx + 1'b1;
        r_wr    <= i_req_rd0_wr1[w_idx];
        r_addr  <= i_req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
        r_wdata <= i_req_wr_data[int'(w_idx)*DATA_W +: DATA_W];
      end
      if (w_done) begin
        r_rd_data <= i_rd_data;
        r_rd_flag <= i_rd_valid;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    o_req_ready    = '0;
    o_req_done     = '0;
    o_req_rd_valid = '0;
    o_req_rd_data  = '0;
    o_valid        = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          o_req_ready[w_idx] = 1'b1;
          w_next             = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          w_next = ARB_WAIT;
        end
      end
      // First ready seen after the handshake is the completion.
      ARB_WAIT: begin
        if (i_ready) begin
          w_next = ARB_RESP;
        end
      end
      ARB_RESP: begin
        o_req_done[r_gid] = 1'b1;
        if (r_rd_flag) begin
          o_req_rd_valid[r_gid] = 1'b1;
          o_req_rd_data         = r_rd_data;
        end
        w_next = ARB_IDLE;
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  assign o_rd0_wr1  = r_wr;
  assign o_addr     = r_addr;
  assign o_wr_data  = r_wdata;
  assign o_busy     = (r_state != ARB_IDLE);
  assign o_grant_id = r_gid;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter with an APB master/slave
// stand-in and a transaction-level reference model.
module tb_apb_req_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_wr;
  logic [127:0] req_addr, req_wdata;
  logic [3:0]   req_ready, req_done, req_rdv;
  logic [31:0]  req_rdata;
  logic         m_valid, m_wr, m_ready, m_rdv;
  logic [31:0]  m_addr, m_wdata, m_rdata;
  logic         busy;
  logic [1:0]   gid;

  always #5 clk = ~clk;

  apb_req_arbiter #(
    .NUM_REQ (4),
    .ADDR_W  (32),
    .DATA_W  (32)
  ) dut (
    .i_clk_apb      (clk),
    .i_rst_apb      (rst),
    .i_req_valid    (req_valid),
    .i_req_rd0_wr1  (req_wr),
    .i_req_addr     (req_addr),
    .i_req_wr_data  (req_wdata),
    .o_req_ready    (req_ready),
    .o_req_done     (req_done),
    .o_req_rd_valid (req_rdv),
    .o_req_rd_data  (req_rdata),
    .o_valid        (m_valid),
    .o_rd0_wr1      (m_wr),
    .o_addr         (m_addr),
    .o_wr_data      (m_wdata),
    .i_ready        (m_ready),
    .i_rd_valid     (m_rdv),
    .i_rd_data      (m_rdata),
    .o_busy         (busy),
    .o_grant_id     (gid)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // requesters
  bit          want[4], acc[4], persist[4];
  bit          rq_wr[4];
  logic [31:0] rq_addr[4], rq_data[4];

  // master + slave stand-in
  int          ms, ms_w;
  bit          ms_wr;
  logic [31:0] ms_addr, ms_data;
  logic [31:0] mem[256];

  // reference model
  bit          md_busy, md_wr;
  int          md_g, md_ptr, md_t, md_w;
  logic [31:0] md_addr, md_data;
  logic [31:0] md_mem[256];
  int          force_w = -1;
  int          max_w = 2;

  logic [112:0] obs_v, exp_v;
  int          gnt_q[$], gnt_cyc_q[$];
  int          hs_cyc, done_cyc, done_id, done_cnt;
  logic [3:0]  done_rdv;
  logic [31:0] done_data;

  function automatic logic [112:0] snap();
    return {req_ready, req_done, req_rdv, req_rdata, m_valid,
            m_wr, m_addr, m_wdata, busy, gid};
  endfunction

  function automatic int pick(logic [3:0] v, int p);
    for (int i = 0; i < 4; i++) begin
      if (v[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic post(input int k, input bit wr,
                      input logic [31:0] a, input logic [31:0] d);
    want[k] = 1'b1;
    acc[k] = 1'b0;
    rq_wr[k] = wr;
    rq_addr[k] = a;
    rq_data[k] = d;
  endtask

  task automatic clear_env();
    for (int k = 0; k < 4; k++) begin
      want[k] = 0; acc[k] = 0; persist[k] = 0;
    end
    ms = 0; ms_w = 0;
    md_busy = 0; md_wr = 0; md_g = 0; md_ptr = 0;
    md_t = 0; md_w = 0; md_addr = '0; md_data = '0;
  endtask

  task automatic step();
    logic [3:0]  e_rdy, e_done, e_rdv;
    logic [31:0] e_rdata;
    logic        e_valid;
    int          g;
    @(negedge clk);
    m_ready = (ms == 0) || (ms == 2 && ms_w == 0);
    m_rdv   = (ms == 2 && ms_w == 0 && !ms_wr);
    m_rdata = m_rdv ? mem[ms_addr[7:0]] : 32'h0;
    for (int k = 0; k < 4; k++) begin
      req_valid[k] = want[k] && !acc[k];
      req_wr[k] = rq_wr[k];
      req_addr[k*32 +: 32] = rq_addr[k];
      req_wdata[k*32 +: 32] = rq_data[k];
    end
    #1;
    e_rdy = '0; e_done = '0; e_rdv = '0; e_rdata = '0;
    e_valid = 1'b0; g = -1;
    if (!md_busy) begin
      g = pick(req_valid, md_ptr);
      if (g >= 0) e_rdy[g] = 1'b1;
    end else begin
      e_valid = (md_t == 1);
      if (md_t == 4 + md_w) begin
        e_done[md_g] = 1'b1;
        if (!md_wr) begin
          e_rdv[md_g] = 1'b1;
          e_rdata = md_mem[md_addr[7:0]];
        end
      end
    end
    exp_v = {e_rdy, e_done, e_rdv, e_rdata, e_valid, md_wr,
             md_addr, md_data, md_busy, 2'(md_g)};
    obs_v = snap();
    for (int k = 0; k < 4; k++) begin
      if (req_ready[k]) begin
        gnt_q.push_back(k);
        gnt_cyc_q.push_back(cyc);
      end
      if (req_done[k]) begin
        done_cyc = cyc; done_id = k; done_cnt++;
        done_rdv = req_rdv; done_data = req_rdata;
      end
    end
    if (m_valid && m_ready) hs_cyc = cyc;
    if (md_busy) begin
      if (md_t == 4 + md_w) begin
        md_busy = 0;
        if (md_wr) md_mem[md_addr[7:0]] = md_data;
      end else md_t++;
    end else if (g >= 0) begin
      md_busy = 1; md_t = 1; md_g = g; md_ptr = (g + 1) % 4;
      md_wr = rq_wr[g]; md_addr = rq_addr[g]; md_data = rq_data[g];
      md_w = (force_w >= 0) ? force_w : int'($urandom_range(0, max_w));
    end
    case (ms)
      0: if (m_valid) begin
        ms = 1; ms_wr = m_wr; ms_addr = m_addr;
        ms_data = m_wdata; ms_w = md_w;
      end
      1: ms = 2;
      default: begin
        if (ms_w == 0) begin
          ms = 0;
          if (ms_wr) mem[ms_addr[7:0]] = ms_data;
        end else ms_w--;
      end
    endcase
    for (int k = 0; k < 4; k++) begin
      if (req_ready[k]) acc[k] = 1'b1;
      if (req_done[k]) begin
        acc[k] = 1'b0;
        want[k] = persist[k];
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0; m_ready = 0; m_rdv = 0; m_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    clear_env();
    #1;
    obs_v = snap();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    m_ready = 0; m_rdv = 0; m_rdata = '0;
    clear_env();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (snap() !== 113'd0) begin
      n_err++;
      $display("FAIL reset_state got %h want 0", snap());
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    int c0, d0;
    gnt_q.delete(); gnt_cyc_q.delete();
    force_w = 0; c0 = cyc; d0 = done_cnt;
    post(2, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    for (int i = 0; i < 20 && done_cnt == d0; i++) begin
      step(); n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL single_write cyc %0d got %h want %h",
                 cyc, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (gnt_cyc_q.size() != 1 || gnt_q[0] != 2
        || gnt_cyc_q[0] != c0) begin
      n_err++;
      $display("FAIL single_write_grant got %p want id2@%0d",
               gnt_cyc_q, c0);
    end
    n_cmp++;
    if (hs_cyc != c0 + 1 || done_cyc != c0 + 4 || done_id != 2) begin
      n_err++;
      $display("FAIL single_write_timing got hs%0d done%0d id%0d want hs%0d done%0d id2",
               hs_cyc, done_cyc, done_id, c0 + 1, c0 + 4);
    end
    n_cmp++;
    if (done_rdv !== 4'b0 || mem[8'h10] !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL single_write_data got rdv%h mem%h want 0 deadbeef",
               done_rdv, mem[8'h10]);
    end
  endtask

  task automatic test_read_wait();
    int c0, d0;
    mem[8'h20] = 32'h1234_5678;
    md_mem[8'h20] = 32'h1234_5678;
    force_w = 3; c0 = cyc; d0 = done_cnt;
    post(0, 1'b0, 32'h0000_0020, 32'h0);
    for (int i = 0; i < 20 && done_cnt == d0; i++) begin
      step(); n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL read_wait cyc %0d got %h want %h",
                 cyc, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (done_cyc != c0 + 7 || done_id != 0 || done_rdv !== 4'b0001
        || done_data !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL read_wait_resp got c%0d id%0d rdv%h d%h want c%0d id0 rdv1 d12345678",
               done_cyc, done_id, done_rdv, done_data, c0 + 7);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    gnt_q.delete(); gnt_cyc_q.delete();
    force_w = 0;
    for (int k = 0; k < 4; k++) begin
      persist[k] = 1;
      post(k, k[0], 32'h100 + 32'(k * 4), $urandom);
    end
    for (int i = 0; i < 60; i++) begin
      if (gnt_q.size() >= 6) begin
        for (int k = 0; k < 4; k++) persist[k] = 0;
      end
      if (gnt_q.size() >= 6 && !md_busy
          && !(want[0] | want[1] | want[2] | want[3])) break;
      step(); n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL fairness cyc %0d got %h want %h",
                 cyc, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (gnt_q.size() < 6 || gnt_q[0] != 0 || gnt_q[1] != 1
        || gnt_q[2] != 2 || gnt_q[3] != 3 || gnt_q[4] != 0
        || gnt_q[5] != 1) begin
      n_err++;
      $display("FAIL fairness_order got %p want 0 1 2 3 0 1", gnt_q);
    end
    for (int i = 1; i < 6 && i < gnt_cyc_q.size(); i++) begin
      n_cmp++;
      if (gnt_cyc_q[i] - gnt_cyc_q[i-1] != 5) begin
        n_err++;
        $display("FAIL fairness_gap grant %0d got %0d want 5",
                 i, gnt_cyc_q[i] - gnt_cyc_q[i-1]);
      end
    end
  endtask

  task automatic test_ptr_wrap();
    int stage;
    gnt_q.delete(); gnt_cyc_q.delete();
    force_w = 1; stage = 0;
    post(2, 1'b1, 32'h30, 32'hA5A5_0002);
    for (int i = 0; i < 80 && stage < 4; i++) begin
      if (!md_busy && !(want[0] | want[1] | want[2] | want[3])) begin
        if (stage == 0) begin
          post(3, 1'b1, 32'h34, 32'hA5A5_0003);
          post(1, 1'b0, 32'h38, 32'h0);
        end else if (stage == 1) begin
          post(1, 1'b1, 32'h3C, 32'hA5A5_0011);
          post(2, 1'b0, 32'h30, 32'h0);
        end
        stage++;
      end
      if (stage < 4) begin
        step(); n_cmp++;
        if (obs_v !== exp_v) begin
          n_err++;
          $display("FAIL ptr_wrap cyc %0d got %h want %h",
                   cyc, obs_v, exp_v);
        end
      end
    end
    n_cmp++;
    if (gnt_q.size() != 5 || gnt_q[1] != 3 || gnt_q[2] != 1
        || gnt_q[3] != 2) begin
      n_err++;
      $display("FAIL ptr_wrap_order got %p want 2 3 1 2 1", gnt_q);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    gnt_q.delete(); gnt_cyc_q.delete();
    force_w = 3;
    post(1, 1'b1, 32'h44, 32'hCAFE_0001);
    repeat (3) step();
    d0 = done_cnt;
    do_reset();
    n_cmp++;
    if (obs_v !== 113'd0) begin
      n_err++;
      $display("FAIL reset_mid_outputs got %h want 0", obs_v);
    end
    for (int i = 0; i < 8; i++) begin
      step(); n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid_idle cyc %0d got %h want %h",
                 cyc, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (done_cnt != d0) begin
      n_err++;
      $display("FAIL reset_mid_nodone got %0d want %0d", done_cnt, d0);
    end
    gnt_q.delete();
    force_w = 0;
    post(1, 1'b0, 32'h48, 32'h0);
    post(3, 1'b0, 32'h4C, 32'h0);
    for (int i = 0; i < 40; i++) begin
      if (!md_busy && !(want[0] | want[1] | want[2] | want[3])) break;
      step(); n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid_run cyc %0d got %h want %h",
                 cyc, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (gnt_q.size() != 2 || gnt_q[0] != 1 || gnt_q[1] != 3) begin
      n_err++;
      $display("FAIL reset_mid_first got %p want 1 3", gnt_q);
    end
  endtask

  task automatic test_late_arrival();
    int d0, dc;
    gnt_q.delete(); gnt_cyc_q.delete();
    force_w = 2; d0 = done_cnt; dc = -1;
    post(0, 1'b1, 32'h50, 32'hBEEF_0000);
    for (int i = 0; i < 40; i++) begin
      if (i == 3) post(1, 1'b0, 32'h54, 32'h0);
      if (i > 3 && !md_busy
          && !(want[0] | want[1] | want[2] | want[3])) break;
      step(); n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL late_arrival cyc %0d got %h want %h",
                 cyc, obs_v, exp_v);
      end
      if (done_cnt == d0 + 1 && dc < 0) dc = done_cyc;
    end
    n_cmp++;
    if (gnt_q.size() != 2 || gnt_q[1] != 1
        || gnt_cyc_q[1] != dc + 1) begin
      n_err++;
      $display("FAIL late_arrival_grant got %p at %p want 0 1 with r1 at %0d",
               gnt_q, gnt_cyc_q, dc + 1);
    end
  endtask

  task automatic test_random();
    force_w = -1; max_w = 3;
    for (int i = 0; i < 600; i++) begin
      if (i < 500) begin
        for (int k = 0; k < 4; k++) begin
          if (!want[k] && $urandom_range(0, 2) == 0)
            post(k, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
      end else if (!md_busy
                   && !(want[0] | want[1] | want[2] | want[3])) break;
      step(); n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL random cyc %0d got %h want %h",
                 cyc, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (md_busy || want[0] || want[1] || want[2] || want[3]) begin
      n_err++;
      $display("FAIL random_drain got busy%0d want idle", md_busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      md_mem[i] = mem[i];
    end
    test_reset();
    test_single_write();
    test_read_wait();
    test_fairness();
    test_ptr_wrap();
    test_reset_mid();
    test_late_arrival();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
